ro_freq_meas_ctrl: RTL and testbench

//  Measurement-window controller directly downstream of the RO/clock edge counter.

---
 rtl/ro_meas_pkg.sv | 16 +
 rtl/ro_meas_timer.sv | 23 ++
 rtl/ro_freq_meas_ctrl.sv | 100 ++++++++++
 tb/tb_ro_freq_meas_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared state encoding, default constants and width helper for the RO measurement controller.
package ro_meas_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, STOP, CAPTURE, DONE} state_e;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_WIN_W   = 16;
    localparam int DEF_WINDOW  = 1000;
    localparam int DEF_CLR_CYC = 4;
    localparam int DEF_SETTLE  = 8;

    function automatic int diff_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/ro_meas_timer.sv
// ro_meas_timer: loadable phase down-counter; zero_o flags the last cycle of the loaded phase.
module ro_meas_timer #(
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             ld_i,
    input  logic [WIN_W-1:0] ld_val_i,
    output logic             zero_o
);

    logic [WIN_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = ld_i ? ld_val_i : (cnt_q != '0 ? cnt_q - WIN_W'(1) : cnt_q);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/ro_freq_meas_ctrl.sv
// ro_freq_meas_ctrl: sequences RO enable / counter clear / window / settle, then captures both counts
// and their signed difference onto a valid/ready result port.
module ro_freq_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int WINDOW  = DEF_WINDOW,
    parameter int CLR_CYC = DEF_CLR_CYC,
    parameter int SETTLE  = DEF_SETTLE
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [CNT_W-1:0]          ro0Cnt,
    input  logic [CNT_W-1:0]          ro1Cnt,
    output logic                      roEn,
    output logic                      cntRst,
    output logic                      busy,
    output logic                      measValid,
    input  logic                      measReady,
    output logic [CNT_W-1:0]          ro0Meas,
    output logic [CNT_W-1:0]          ro1Meas,
    output logic [diff_w(CNT_W)-1:0]  diff,
    output logic                      dead
);

    state_e                    state_q, state_d;
    logic                      ro_en_q, cnt_rst_q, busy_q, valid_q, dead_q;
    logic [CNT_W-1:0]          ro0_q, ro1_q;
    logic [diff_w(CNT_W)-1:0]  diff_q;
    logic                      zero, ld, hs;
    logic [WIN_W-1:0]          ld_val;

    assign hs = valid_q && measReady;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   if (zero) state_d = RUN;
            RUN:     if (zero) state_d = STOP;
            STOP:    if (zero) state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    if (hs) state_d = continuous ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timer reloads on every phase change; the value only matters for the timed phases.
    assign ld     = state_d != state_q;
    assign ld_val = state_d == CLEAR ? WIN_W'(CLR_CYC - 1) :
                    state_d == RUN   ? WIN_W'(WINDOW - 1)  : WIN_W'(SETTLE - 1);

    ro_meas_timer #(.WIN_W(WIN_W)) u_timer (
        .clk      (clk),
        .rstN     (rstN),
        .ld_i     (ld),
        .ld_val_i (ld_val),
        .zero_o   (zero)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            ro_en_q   <= 1'b0;
            cnt_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            ro0_q     <= '0;
            ro1_q     <= '0;
            diff_q    <= '0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ro_en_q   <= state_d == CLEAR || state_d == RUN;
            cnt_rst_q <= state_d == IDLE || state_d == CLEAR;
            busy_q    <= state_d != IDLE;
            valid_q   <= state_d == DONE;
            // Counts are unsigned, so extension to the diff width is with a zero MSB.
            if (state_q == CAPTURE) begin
                ro0_q  <= ro0Cnt;
                ro1_q  <= ro1Cnt;
                diff_q <= {1'b0, ro0Cnt} - {1'b0, ro1Cnt};
                dead_q <= ro0Cnt == '0 || ro1Cnt == '0;
            end
        end
    end

    assign roEn      = ro_en_q;
    assign cntRst    = cnt_rst_q;
    assign busy      = busy_q;
    assign measValid = valid_q;
    assign ro0Meas   = ro0_q;
    assign ro1Meas   = ro1_q;
    assign diff      = diff_q;
    assign dead      = dead_q;

endmodule

// File: tb/tb_ro_freq_meas_ctrl.sv
// tb_ro_freq_meas_ctrl: ideal gated RO clocks drive a model counter bank; results are scoreboarded
// against table rows and hand-written continuous / reset sequences.
module tb_ro_freq_meas_ctrl;

    localparam int LAT = 1014;

    logic        clk, rstN, start, continuous, measReady;
    logic        roEn, cntRst, busy, measValid, dead;
    logic [15:0] ro0Meas, ro1Meas;
    logic [16:0] diff;
    logic [15:0] c0 = '0, c1 = '0;
    logic        ro0 = 1'b0, ro1 = 1'b0, kill1 = 1'b0;

    ro_freq_meas_ctrl dut (
        .clk        (clk),
        .rstN       (rstN),
        .start      (start),
        .continuous (continuous),
        .ro0Cnt     (c0),
        .ro1Cnt     (c1),
        .roEn       (roEn),
        .cntRst     (cntRst),
        .busy       (busy),
        .measValid  (measValid),
        .measReady  (measReady),
        .ro0Meas    (ro0Meas),
        .ro1Meas    (ro1Meas),
        .diff       (diff),
        .dead       (dead)
    );

    // clk period 1000 units; RO0 period 310, RO1 period 330 (same ratios as 10 / 3.1 / 3.3 ns)
    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end
    initial forever begin
        #155;
        if (roEn) ro0 = ~ro0;
    end
    initial forever begin
        #165;
        if (roEn && !kill1) ro1 = ~ro1;
    end
    always @(posedge ro0 or posedge cntRst) c0 <= cntRst ? '0 : c0 + 16'd1;
    always @(posedge ro1 or posedge cntRst) c1 <= cntRst ? '0 : c1 + 16'd1;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic dead;
        int   lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int   ready_dly;
        logic kill;
        logic exp_dead;
    } vec_t;
    vec_t vt[3];

    task automatic check_result(input string nm, input int n);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_latency"}, n, e.lat);
        chk({nm, "_dead"}, dead, e.dead);
        chk({nm, "_ro0"}, ro0Meas, c0);
        chk({nm, "_ro1"}, ro1Meas, c1);
        chk({nm, "_diff"}, $signed(diff), int'(c0) - int'(c1));
        if (!e.dead) begin
            chk({nm, "_ro0_range"}, ro0Meas >= 3222 && ro0Meas <= 3230, 1);
            chk({nm, "_ro1_range"}, ro1Meas >= 3027 && ro1Meas <= 3034, 1);
        end else begin
            chk({nm, "_ro1_zero"}, ro1Meas, 0);
            chk({nm, "_diff_eq_ro0"}, $signed(diff), int'(ro0Meas));
        end
    endtask

    int          n, rst_cnt, seen;
    logic        stable;
    logic [15:0] s0, s1;
    logic [16:0] sd;

    initial begin
        vt[0] = '{0,  1'b0, 1'b0};
        vt[1] = '{50, 1'b0, 1'b0};
        vt[2] = '{0,  1'b1, 1'b1};
        rstN = 1'b0; start = 1'b0; continuous = 1'b0; measReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_roEn", roEn, 0);
        chk("rst_cntRst", cntRst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", measValid, 0);
        chk("rst_data", {ro0Meas, ro1Meas, diff, dead}, 0);
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_roEn", roEn, 0);

        for (int i = 0; i < 3; i++) begin
            kill1     = vt[i].kill;
            measReady = vt[i].ready_dly == 0;
            start     = 1'b1;
            sb.push_back('{vt[i].exp_dead, LAT});
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) start = 1'b0;
            end while (!measValid && n < 2000);
            if (!measValid) chk($sformatf("row%0d_timeout", i), 0, 1);
            check_result($sformatf("row%0d", i), n);
            if (vt[i].ready_dly > 0) begin
                s0 = ro0Meas; s1 = ro1Meas; sd = diff; stable = 1'b1;
                repeat (vt[i].ready_dly) begin
                    @(negedge clk);
                    stable &= ro0Meas == s0 && ro1Meas == s1 && diff == sd && measValid && !roEn && busy;
                end
                chk($sformatf("row%0d_backpressure_hold", i), stable, 1);
                measReady = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("row%0d_valid_drop", i), measValid, 0);
            chk($sformatf("row%0d_idle", i), {busy, roEn, cntRst}, 3'b001);
            measReady = 1'b0;
            kill1 = 1'b0;
        end

        continuous = 1'b1; measReady = 1'b1; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b0, LAT});
            n = 0; rst_cnt = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) start = 1'b0;
                rst_cnt += int'(cntRst);
                if (k == 2 && n == 500) continuous = 1'b0;
            end while (!measValid && n < 2000);
            if (!measValid) chk($sformatf("cont%0d_timeout", k), 0, 1);
            check_result($sformatf("cont%0d", k), n);
            chk($sformatf("cont%0d_cntRst_cycles", k), rst_cnt, 4);
        end
        @(negedge clk);
        chk("cont_stop_idle", {busy, measValid}, 2'b00);
        measReady = 1'b0;

        start = 1'b1;
        n = 0;
        repeat (500) begin
            @(negedge clk);
            n++;
            start = n == 300;
        end
        chk("midrun_busy", {busy, roEn, cntRst}, 3'b110);
        #200 rstN = 1'b0;
        #1;
        chk("midrun_rst_ctrl", {roEn, cntRst, busy, measValid}, 4'b0100);
        chk("midrun_rst_data", {ro0Meas, ro1Meas, diff, dead}, 0);
        @(negedge clk);
        rstN = 1'b1;
        seen = 0;
        repeat (1100) begin
            @(negedge clk);
            seen += int'(measValid || busy);
        end
        chk("midrun_no_extra", seen, 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
